fastram_ctrl: RTL and testbench
===============================

FASTRAM_CTRL -- requirements
Module: fastram_ctrl

Interface
REQ-001 The block SHALL take parameter NUM_BANKS, default 2: number of RAM banks (1..4).
REQ-002 The block SHALL take parameter BANK_SLOTS, default 2: 2 MB Zorro II slots per bank (1 or 2); NUM_BANKS*BANK_SLOTS SHALL be at most 4.
REQ-003 The block SHALL take parameter WAIT_STATES, default 0: extra CLK cycles inserted before strobes (0..7).
REQ-004 The block SHALL have: CLK  in  1  single system clock; all logic on the rising edge.
REQ-005 The block SHALL have: RESET  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have: A  in  3 [23:21]  CPU address high bits.
REQ-007 The block SHALL have: RW_n, AS_n, UDS_n, LDS_n  in  1 each  asynchronous 68000 bus strobes.
REQ-008 The block SHALL have: BASE_RAM  in  3 [7:5]  autoconfig base slot; RAM_CONFIGURED_n  in  1  low once configured.
REQ-009 The block SHALL have: BANK_EN  in  NUM_BANKS  per-bank enable, replacing the single jumper input.
REQ-010 The block SHALL have: OE_n, WE_ODD_n, WE_EVEN_n  out  NUM_BANKS each  registered, active-low per-bank strobes.
REQ-011 The block SHALL have: DTACK_n  out  1  registered, active-low transfer acknowledge; RAM_ACCESS  out  1  high while a claimed cycle is in progress.

Function
REQ-012 AS_n, UDS_n and LDS_n SHALL pass through two-flop synchronisers; all decisions use the synchronised values.
REQ-013 Slot offset SHALL be (A - BASE_RAM) modulo 8, 3-bit wrap; bank index = offset / BANK_SLOTS; hit iff offset < NUM_BANKS*BANK_SLOTS, BANK_EN[bank] = 1 and RAM_CONFIGURED_n = 0.
REQ-014 The FSM SHALL have states IDLE, WAIT, ACTIVE and DONE.
REQ-015 In IDLE, synchronised AS low with a hit SHALL latch bank index and RW_n. It SHALL go to WAIT with counter = WAIT_STATES, or straight to ACTIVE if WAIT_STATES = 0. A miss SHALL stay in IDLE.
REQ-016 In WAIT, the counter SHALL decrement each cycle; at counter = 1 the FSM SHALL go to ACTIVE on the next edge, so exactly WAIT_STATES cycles are spent in WAIT.
REQ-017 In ACTIVE, for the latched bank only: OE_n low iff read and (UDS or LDS low); WE_ODD_n low iff write and LDS low; WE_EVEN_n low iff write and UDS low. DTACK_n SHALL be low. All other banks' strobes SHALL stay high.
REQ-018 In ACTIVE, strobes SHALL follow the synchronised UDS/LDS each cycle (late-DS writes).
REQ-019 Synchronised AS high in WAIT or ACTIVE SHALL go to DONE. DONE SHALL drive all strobes and DTACK_n high for one cycle, then go to IDLE. Back-to-back cycles therefore have at least one idle cycle.
REQ-020 RAM_CONFIGURED_n going high in WAIT or ACTIVE SHALL abort to DONE.
REQ-021 A, BASE_RAM and BANK_EN changes after the latch SHALL NOT affect the current cycle.
REQ-022 RAM_ACCESS SHALL be high in WAIT and ACTIVE only.
REQ-023 Latency: CLK edges from AS_n falling to DTACK_n low SHALL be 2 (synchronisers) + 1 + WAIT_STATES, registered outputs included.

Reset
REQ-024 On RESET, the next edge SHALL force IDLE, counter 0, synchronisers to 1, all OE_n/WE_*_n/DTACK_n high and RAM_ACCESS low, including mid-cycle.
REQ-025 After RESET is released, a cycle whose AS_n is already low SHALL be claimed only once the synchronisers show AS low.

Structure
REQ-026 A package fastram_pkg SHALL hold the FSM state enum, the slot width constant (3) and the Z2 slot range constants (first 3'b001, last 3'b100).
REQ-027 A sub-module bus_sync (parameterised width, two-flop, synchronous reset to 1) SHALL implement the synchronisers.
REQ-028 Parameter legality (NUM_BANKS*BANK_SLOTS <= 4) SHALL be checked at elaboration.

Verification
REQ-029 NUM_BANKS=2, BANK_SLOTS=2, WAIT_STATES=0, BASE=3'b001, A=3'b010, read, UDS=LDS=0 -> OE_n=2'b10, DTACK_n low 3 edges after AS_n falls; both high in DONE after AS_n rises.
REQ-030 Same configuration, A=3'b011, write, LDS only -> WE_ODD_n=2'b01, WE_EVEN_n=2'b11, OE_n=2'b11.
REQ-031 BANK_EN=2'b01, A=3'b100 -> no strobes, RAM_ACCESS stays 0, DTACK_n stays 1.
REQ-032 WAIT_STATES=3 -> DTACK_n low 6 edges after AS_n falls; RAM_ACCESS high in WAIT and ACTIVE.
REQ-033 BASE=3'b111, A=3'b000 (wrap), NUM_BANKS=1, BANK_SLOTS=2 -> bank 0 hit. RESET asserted during ACTIVE -> all outputs inactive on the next edge.
REQ-034 RAM_CONFIGURED_n going high during WAIT -> DONE, then IDLE, with no strobe asserted.

Source files
------------

// File: rtl/fastram_pkg.sv
// fastram_pkg -- shared definitions for the Zorro II fast-RAM controller.
//
// Contents:
//   SLOT_W          width of a 2 MB Zorro II slot number (address bits 23:21)
//   Z2_SLOT_FIRST   first slot the Zorro II expansion space can occupy
//   Z2_SLOT_LAST    last slot the Zorro II expansion space can occupy
//   fsm_state_t     bus-cycle FSM states
//   slot_offset()   slot distance from the autoconfig base, 3-bit wrap
package fastram_pkg;

    localparam int SLOT_W = 3;

    localparam logic [SLOT_W-1:0] Z2_SLOT_FIRST = 3'b001;
    localparam logic [SLOT_W-1:0] Z2_SLOT_LAST  = 3'b100;

    // ST_ prefix because "wait" is a reserved word.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } fsm_state_t;

    // Modulo-8 subtraction falls out of the 3-bit result width, so a base
    // near the top of the slot range wraps cleanly into slot 0.
    function automatic logic [SLOT_W-1:0] slot_offset(
        input logic [SLOT_W-1:0] addr_slot,
        input logic [SLOT_W-1:0] base_slot
    );
        return addr_slot - base_slot;
    endfunction

endpackage

// File: rtl/bus_sync.sv
// bus_sync -- two-flop synchroniser for asynchronous bus strobes.
//
// Ports:
//   clk   in   system clock
//   srst  in   synchronous active-high reset; both stages go to 1 (strobes
//              are active-low, so 1 means "not asserted")
//   d     in   [WIDTH-1:0] asynchronous inputs
//   q     out  [WIDTH-1:0] synchronised outputs, two clk edges behind d
module bus_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk) begin
            if (srst) begin
                meta_reg[gi] <= 1'b1;
                sync_reg[gi] <= 1'b1;
            end else begin
                meta_reg[gi] <= d[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/fastram_ctrl.sv
// fastram_ctrl -- 68000 / Zorro II fast-RAM bank controller.
//
// Decodes the CPU's high address bits against the autoconfig base, claims
// cycles that land in an enabled bank, and drives registered active-low
// per-bank output/write strobes plus DTACK_n.
//
// Ports:
//   CLK               in   system clock, rising edge
//   RESET             in   synchronous active-high reset
//   A[23:21]          in   CPU address slot bits
//   RW_n              in   1 = read, 0 = write
//   AS_n,UDS_n,LDS_n  in   asynchronous 68000 strobes (synchronised here)
//   BASE_RAM[7:5]     in   autoconfig base slot
//   RAM_CONFIGURED_n  in   low once the board has been configured
//   BANK_EN           in   [NUM_BANKS] per-bank enable
//   OE_n              out  [NUM_BANKS] output enable, active low
//   WE_ODD_n          out  [NUM_BANKS] odd-byte (LDS) write enable, active low
//   WE_EVEN_n         out  [NUM_BANKS] even-byte (UDS) write enable, active low
//   DTACK_n           out  transfer acknowledge, active low
//   RAM_ACCESS        out  high while a claimed cycle is in WAIT or ACTIVE
module fastram_ctrl
    import fastram_pkg::*;
#(
    parameter int NUM_BANKS   = 2,
    parameter int BANK_SLOTS  = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [23:21]         A,
    input  logic                 RW_n,
    input  logic                 AS_n,
    input  logic                 UDS_n,
    input  logic                 LDS_n,
    input  logic [7:5]           BASE_RAM,
    input  logic                 RAM_CONFIGURED_n,
    input  logic [NUM_BANKS-1:0] BANK_EN,
    output logic [NUM_BANKS-1:0] OE_n,
    output logic [NUM_BANKS-1:0] WE_ODD_n,
    output logic [NUM_BANKS-1:0] WE_EVEN_n,
    output logic                 DTACK_n,
    output logic                 RAM_ACCESS
);

    if (NUM_BANKS < 1 || NUM_BANKS > 4 ||
        (BANK_SLOTS != 1 && BANK_SLOTS != 2) ||
        NUM_BANKS * BANK_SLOTS > 4 ||
        WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_params
        $error("fastram_ctrl: illegal NUM_BANKS/BANK_SLOTS/WAIT_STATES combination");
    end

    localparam logic [SLOT_W:0]   TOTAL_SLOTS = (SLOT_W+1)'(NUM_BANKS * BANK_SLOTS);
    localparam logic [2:0]        WAIT_INIT   = 3'(WAIT_STATES);

    // ------------------------------------------------------------------
    // Strobe synchronisers
    // ------------------------------------------------------------------
    logic [2:0] strb_sync;
    logic       as_s;
    logic       uds_s;
    logic       lds_s;

    bus_sync #(
        .WIDTH(3)
    ) u_sync (
        .clk  (CLK),
        .srst (RESET),
        .d    ({AS_n, UDS_n, LDS_n}),
        .q    (strb_sync)
    );

    assign as_s  = strb_sync[2];
    assign uds_s = strb_sync[1];
    assign lds_s = strb_sync[0];

    // ------------------------------------------------------------------
    // Address decode (only consulted in IDLE; the result is latched)
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0]    offset;
    logic [1:0]           bank_idx;
    logic [NUM_BANKS-1:0] bank_sel_en;
    logic                 in_range;
    logic                 hit;

    assign offset   = slot_offset(A, BASE_RAM);
    // Out-of-range offsets produce a junk index, but in_range masks them.
    assign bank_idx = (BANK_SLOTS == 2) ? offset[2:1] : offset[1:0];
    assign in_range = ({1'b0, offset} < TOTAL_SLOTS);

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_sel
        assign bank_sel_en[gi] = BANK_EN[gi] && (bank_idx == 2'(gi));
    end

    assign hit = in_range && (|bank_sel_en) && !RAM_CONFIGURED_n;

    // ------------------------------------------------------------------
    // FSM state
    // ------------------------------------------------------------------
    fsm_state_t state_reg, state_next;
    logic [2:0] cnt_reg,   cnt_next;
    logic [1:0] bank_reg,  bank_next;
    logic       rw_reg,    rw_next;

    logic [NUM_BANKS-1:0] oe_next;
    logic [NUM_BANKS-1:0] we_odd_next;
    logic [NUM_BANKS-1:0] we_even_next;
    logic                 dtack_next;
    logic                 ram_access_next;
    logic [NUM_BANKS-1:0] bank_active;

    // State register plus the registered outputs. The outputs are loaded
    // from the next-state decode so they change on the same edge the FSM
    // enters a state, which keeps the AS-to-DTACK latency at 3 + waits.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 3'd0;
            bank_reg   <= 2'd0;
            rw_reg     <= 1'b1;
            OE_n       <= '1;
            WE_ODD_n   <= '1;
            WE_EVEN_n  <= '1;
            DTACK_n    <= 1'b1;
            RAM_ACCESS <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bank_reg   <= bank_next;
            rw_reg     <= rw_next;
            OE_n       <= oe_next;
            WE_ODD_n   <= we_odd_next;
            WE_EVEN_n  <= we_even_next;
            DTACK_n    <= dtack_next;
            RAM_ACCESS <= ram_access_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bank_next  = bank_reg;
        rw_next    = rw_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!as_s && hit) begin
                    bank_next  = bank_idx;
                    rw_next    = RW_n;
                    cnt_next   = WAIT_INIT;
                    state_next = (WAIT_STATES == 0) ? ST_ACTIVE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (as_s || RAM_CONFIGURED_n) begin
                    state_next = ST_DONE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_next = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (as_s || RAM_CONFIGURED_n) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: strobes track the synchronised data strobes every
    // cycle in ACTIVE so a late UDS/LDS on a write still lands.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_active
        assign bank_active[gi] = (state_next == ST_ACTIVE) && (bank_next == 2'(gi));
    end

    always_comb begin
        oe_next         = ~(bank_active & {NUM_BANKS{rw_next && (!uds_s || !lds_s)}});
        we_odd_next     = ~(bank_active & {NUM_BANKS{!rw_next && !lds_s}});
        we_even_next    = ~(bank_active & {NUM_BANKS{!rw_next && !uds_s}});
        dtack_next      = (state_next != ST_ACTIVE);
        ram_access_next = (state_next == ST_WAIT) || (state_next == ST_ACTIVE);
    end

endmodule

// File: tb/tb_fastram_ctrl.sv
// tb_fastram_ctrl -- self-checking bench for fastram_ctrl.
//
// Two instances share the bus: dut0 (2 banks x 2 slots, no wait states) and
// dut1 (1 bank x 2 slots, 3 wait states). Inputs change on the falling edge,
// outputs are sampled on the falling edge. A cycle-level reference model,
// written from the bus rules (strobes seen two edges late, claim on a hit,
// wait count by elapsed edges), is compared against both instances on every
// falling edge; directed table vectors and hand sequences add explicit checks.
module tb_fastram_ctrl;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET;
    logic [2:0] A;
    logic [2:0] BASE;
    logic       RW_n, AS_n, UDS_n, LDS_n, CFG_n;
    logic [1:0] be0;
    logic [0:0] be1;

    logic [1:0] oe0, wo0, we0;
    logic       dt0, ra0;
    logic [0:0] oe1, wo1, we1;
    logic       dt1, ra1;

    fastram_ctrl #(.NUM_BANKS(2), .BANK_SLOTS(2), .WAIT_STATES(0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .A(A), .RW_n(RW_n), .AS_n(AS_n),
        .UDS_n(UDS_n), .LDS_n(LDS_n), .BASE_RAM(BASE),
        .RAM_CONFIGURED_n(CFG_n), .BANK_EN(be0), .OE_n(oe0),
        .WE_ODD_n(wo0), .WE_EVEN_n(we0), .DTACK_n(dt0), .RAM_ACCESS(ra0)
    );

    fastram_ctrl #(.NUM_BANKS(1), .BANK_SLOTS(2), .WAIT_STATES(3)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .A(A), .RW_n(RW_n), .AS_n(AS_n),
        .UDS_n(UDS_n), .LDS_n(LDS_n), .BASE_RAM(BASE),
        .RAM_CONFIGURED_n(CFG_n), .BANK_EN(be1), .OE_n(oe1),
        .WE_ODD_n(wo1), .WE_EVEN_n(we1), .DTACK_n(dt1), .RAM_ACCESS(ra1)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        int         mode;   // 0 idle, 1 claimed, 2 done
        int         c;      // edge number of the claim
        int         bank;
        logic       rw;
        logic [3:0] oe;
        logic [3:0] wo;
        logic [3:0] we;
        logic       dt;
        logic       ra;
    } model_t;

    localparam model_t IDLE_M = '{mode: 0, c: 0, bank: 0, rw: 1'b1,
                                  oe: 4'hF, wo: 4'hF, we: 4'hF, dt: 1'b1, ra: 1'b0};

    function automatic model_t model_step(
        input model_t     m,
        input int         nb,
        input int         bs,
        input int         ws,
        input int         edge_n,
        input logic       rst,
        input logic       as_s,
        input logic       uds_s,
        input logic       lds_s,
        input logic       rw,
        input logic       cfg,
        input logic [2:0] a,
        input logic [2:0] base,
        input logic [3:0] be
    );
        model_t n;
        int     off;
        n    = m;
        off  = (int'(a) - int'(base) + 8) % 8;
        n.oe = 4'hF;
        n.wo = 4'hF;
        n.we = 4'hF;
        n.dt = 1'b1;
        n.ra = 1'b0;
        if (rst) begin
            n.mode = 0;
            return n;
        end
        case (m.mode)
            0: if (!as_s && !cfg && off < nb * bs && be[off / bs]) begin
                n.mode = 1;
                n.c    = edge_n;
                n.bank = off / bs;
                n.rw   = rw;
            end
            1: if (as_s || cfg) n.mode = 2;
            default: n.mode = 0;
        endcase
        if (n.mode == 1) begin
            n.ra = 1'b1;
            if (edge_n - n.c >= ws) begin
                n.dt = 1'b0;
                if (n.rw && (!uds_s || !lds_s)) n.oe[n.bank] = 1'b0;
                if (!n.rw && !lds_s)            n.wo[n.bank] = 1'b0;
                if (!n.rw && !uds_s)            n.we[n.bank] = 1'b0;
            end
        end
        return n;
    endfunction

    model_t     m0 = IDLE_M;
    model_t     m1 = IDLE_M;
    int         edge_n = 0;
    logic       rst_h1 = 1'b1, rst_h2 = 1'b1;
    logic [2:0] strb_h1 = 3'b111, strb_h2 = 3'b111;
    logic [2:0] strb_seen;

    // Strobes become visible two edges after they are sampled, and a reset
    // in either of the last two edges makes them read as idle.
    assign strb_seen = (rst_h1 || rst_h2) ? 3'b111 : strb_h2;

    always @(posedge CLK) begin
        m0 <= model_step(m0, 2, 2, 0, edge_n, RESET, strb_seen[2], strb_seen[1],
                         strb_seen[0], RW_n, CFG_n, A, BASE, {2'b00, be0});
        m1 <= model_step(m1, 1, 2, 3, edge_n, RESET, strb_seen[2], strb_seen[1],
                         strb_seen[0], RW_n, CFG_n, A, BASE, {3'b000, be1});
        strb_h2 <= strb_h1;
        strb_h1 <= {AS_n, UDS_n, LDS_n};
        rst_h2  <= rst_h1;
        rst_h1  <= RESET;
        edge_n  <= edge_n + 1;
    end

    // ------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        checks++;
        if ({oe0, wo0, we0, dt0, ra0} !== {m0.oe[1:0], m0.wo[1:0], m0.we[1:0], m0.dt, m0.ra}) begin
            errors++;
            $display("FAIL model dut0 edge %0d: got oe=%b wo=%b we=%b dt=%b ra=%b, want oe=%b wo=%b we=%b dt=%b ra=%b",
                     edge_n, oe0, wo0, we0, dt0, ra0, m0.oe[1:0], m0.wo[1:0], m0.we[1:0], m0.dt, m0.ra);
        end
        checks++;
        if ({oe1, wo1, we1, dt1, ra1} !== {m1.oe[0], m1.wo[0], m1.we[0], m1.dt, m1.ra}) begin
            errors++;
            $display("FAIL model dut1 edge %0d: got oe=%b wo=%b we=%b dt=%b ra=%b, want oe=%b wo=%b we=%b dt=%b ra=%b",
                     edge_n, oe1, wo1, we1, dt1, ra1, m1.oe[0], m1.wo[0], m1.we[0], m1.dt, m1.ra);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (chk_en) compare_model();
    endtask

    // ------------------------------------------------------------------
    // Directed vectors for dut0 (AS_n low for 4 cycles)
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0] a;
        logic [2:0] base;
        logic       rw;
        logic       uds;
        logic       lds;
        logic [1:0] be;
        logic [1:0] oe;
        logic [1:0] wo;
        logic [1:0] we;
        logic       dt;
    } vec_t;

    vec_t vt[9];

    task automatic run_vec(input vec_t v, input int idx);
        A = v.a; BASE = v.base; be0 = v.be; be1 = 1'b1;
        RW_n = v.rw; UDS_n = v.uds; LDS_n = v.lds; AS_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) chk($sformatf("vec%0d early dtack", idx), 8'(dt0), 8'h01);
            if (k == 3) begin
                chk($sformatf("vec%0d oe", idx),     8'(oe0), 8'(v.oe));
                chk($sformatf("vec%0d we_odd", idx), 8'(wo0), 8'(v.wo));
                chk($sformatf("vec%0d we_even", idx), 8'(we0), 8'(v.we));
                chk($sformatf("vec%0d dtack", idx),  8'(dt0), 8'(v.dt));
                chk($sformatf("vec%0d ram_access", idx), 8'(ra0), 8'(!v.dt));
            end
            if (k == 4) begin
                AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
            end
            if (k == 6) chk($sformatf("vec%0d dtack held", idx), 8'(dt0), 8'(v.dt));
            if (k == 7) chk($sformatf("vec%0d done", idx), 8'({dt0, ra0, oe0}), 8'b1011);
        end
        $display("vec %0d: a=%0d base=%0d rw=%0b uds=%0b lds=%0b be=%b", idx, v.a, v.base,
                 v.rw, v.uds, v.lds, v.be);
    endtask

    initial begin
        int hold, gap, rst_at;

        RESET = 1'b1; A = 3'd0; BASE = 3'd1; RW_n = 1'b1;
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; CFG_n = 1'b0;
        be0 = 2'b11; be1 = 1'b1;

        repeat (3) tick();
        chk_en = 1'b1;
        compare_model();
        chk("reset dut0", 8'({oe0, wo0, we0, dt0, ra0}), 8'b1111_1110);
        chk("reset dut1", 8'({oe1, wo1, we1, dt1, ra1}), 8'b0001_1110);
        RESET = 1'b0;
        repeat (3) tick();

        //          a     base  rw    uds   lds   be     oe     wo     we     dt
        vt[0] = '{3'd2, 3'd1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 2'b11, 2'b11, 1'b0};
        vt[1] = '{3'd3, 3'd1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 2'b01, 2'b11, 1'b0};
        vt[2] = '{3'd4, 3'd1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b11, 2'b11, 2'b11, 1'b1};
        vt[3] = '{3'd5, 3'd1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1};
        vt[4] = '{3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 2'b10, 1'b0};
        vt[5] = '{3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1};
        vt[6] = '{3'd4, 3'd1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 1'b0};
        vt[7] = '{3'd0, 3'd6, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0};
        vt[8] = '{3'd3, 3'd1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b01, 2'b11, 2'b11, 1'b0};
        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // dut1: wrapped decode, 3 wait states, reset mid-ACTIVE, then a
        // still-low AS_n must wait for the synchronisers to refill.
        A = 3'd0; BASE = 3'd7; be0 = 2'b11; be1 = 1'b1;
        RW_n = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 2) chk("ws early ram_access", 8'(ra1), 8'h00);
            if (k >= 3 && k <= 5) chk($sformatf("ws wait%0d", k), 8'({ra1, dt1}), 8'b11);
            if (k == 6) begin
                chk("ws dtack latency", 8'({dt1, oe1, ra1}), 8'b001);
                RESET = 1'b1;
            end
            if (k == 7) begin
                chk("reset mid active dut1", 8'({oe1, wo1, we1, dt1, ra1}), 8'b11110);
                chk("reset mid active dut0", 8'({dt0, ra0, oe0}), 8'b1011);
                RESET = 1'b0;
            end
            if (k == 8 || k == 9) chk($sformatf("post reset hold%0d", k), 8'(ra1), 8'h00);
            if (k == 10) begin
                chk("post reset reclaim", 8'(ra1), 8'h01);
                AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
            end
        end
        $display("seq wait/wrap/reset done");

        // dut1: configuration withdrawn during WAIT aborts without strobes.
        RW_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) begin
                chk("abort in wait", 8'({ra1, dt1}), 8'b11);
                CFG_n = 1'b1;
            end
            if (k == 4) chk("abort done", 8'({oe1, wo1, we1, dt1, ra1}), 8'b11110);
            if (k == 5) begin
                chk("abort idle", 8'({oe1, wo1, we1, dt1, ra1}), 8'b11110);
                AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
            end
            if (k == 7) CFG_n = 1'b0;
            if (k == 8) chk("abort no reclaim", 8'({oe1, wo1, we1, dt1, ra1}), 8'b11110);
        end
        $display("seq cfg abort done");

        // Randomised bus cycles, checked by the model on every edge.
        for (int t = 0; t < 150; t++) begin
            A     = 3'($urandom);
            BASE  = 3'($urandom);
            be0   = 2'($urandom);
            be1   = 1'($urandom);
            RW_n  = 1'($urandom);
            CFG_n = ($urandom_range(0, 9) == 0);
            hold  = int'($urandom_range(1, 7));
            gap   = int'($urandom_range(1, 4));
            rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int k = 1; k <= hold; k++) begin
                if (k > 1) tick();
                AS_n  = 1'b0;
                UDS_n = ($urandom_range(0, 2) == 0);
                LDS_n = ($urandom_range(0, 2) == 0);
                RESET = (k == rst_at);
                if (k > 3) begin
                    A    = 3'($urandom);
                    BASE = 3'($urandom);
                    be0  = 2'($urandom);
                    be1  = 1'($urandom);
                end
                if ($urandom_range(0, 19) == 0) CFG_n = ~CFG_n;
            end
            tick();
            AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RESET = 1'b0; CFG_n = 1'b0;
            repeat (gap) tick();
            $display("txn %0d: rw=%0b hold=%0d gap=%0d rst_at=%0d", t, RW_n, hold, gap, rst_at);
        end

        repeat (6) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
